mem_responder: RTL and testbench

- Bus responder (slave) side of the cycle/ack memory interface that cacheController drives as initiator (cyc_m2s, we_m2s, adr_m2s, dat_m2s in; data/ack back).
- Backs a word-addressed storage array with a programmable wait-state count and flags out-of-range accesses with an error pulse.
- Sits between the cache controller and the system; it is the memory model for all cache-level benches and the synthesizable on-chip RAM port.

---
 rtl/mem_bus_pkg.sv | 16 +
 rtl/mem_array.sv | 23 ++
 rtl/mem_responder.sv | 128 ++++++++++++
 tb/tb_mem_responder.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// Shared definitions for the cycle/ack memory bus.
// The cache controller benches use this package too.
package mem_bus_pkg;

  localparam int unsigned DW_DEF    = 32;
  localparam int unsigned AW_DEF    = 8;
  localparam int unsigned TXN_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10,
    TURN = 2'b11
  } state_e;

endpackage

// File: rtl/mem_array.sv
// Word storage with one synchronous write port and one synchronous read port.
// Contents are not reset, so the array can map onto block RAM.
module mem_array #(
  parameter int unsigned DW    = 32,
  parameter int unsigned AW    = 8,
  parameter int unsigned DEPTH = 256
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic          re_i,
  input  logic [AW-1:0] adr_i,
  input  logic [DW-1:0] dat_i,
  output logic [DW-1:0] dat_o
);

  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[adr_i] <= dat_i;
    if (re_i) dat_o <= mem_q[adr_i];
  end

endmodule

// File: rtl/mem_responder.sv
// Responder side of the cycle/ack memory bus: programmable wait states,
// an error pulse for out-of-range addresses, and a completed-transaction counter.
module mem_responder
  import mem_bus_pkg::*;
#(
  parameter int unsigned DW      = DW_DEF,
  parameter int unsigned AW      = AW_DEF,
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cyc_m2s,
  input  logic                 we_m2s,
  input  logic [AW-1:0]        adr_m2s,
  input  logic [DW-1:0]        dat_m2s,
  output logic [DW-1:0]        dat_mem_o,
  output logic                 ack_mem_o,
  output logic                 err_mem_o,
  output logic [TXN_CNT_W-1:0] txn_cnt_o,
  output logic [1:0]           state_test
);

  localparam logic [3:0] LAT_M1 = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  state_e                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   we_q, oor_q;
  logic [AW-1:0]          adr_q;
  logic [DW-1:0]          dat_q;
  logic                   ack_q, err_q, rd_ack_q;
  logic [TXN_CNT_W-1:0]   txn_cnt_q;
  logic                   cap, commit;
  logic                   sel_we, sel_oor;
  logic [AW-1:0]          sel_adr;
  logic [DW-1:0]          sel_dat;
  logic [DW-1:0]          rd_dat;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap     = 1'b0;
    commit  = 1'b0;
    unique case (state_q)
      IDLE: if (cyc_m2s) begin
        cap = 1'b1;
        if (LATENCY > 0) begin
          state_d = WAIT;
          cnt_d   = LAT_M1;
        end else begin
          state_d = RESP;
          commit  = 1'b1;
        end
      end
      WAIT: begin
        if (!cyc_m2s) begin
          state_d = IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d = RESP;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = TURN;
      TURN:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // With zero wait states the commit happens on the capture edge, so use the live inputs.
  always_comb begin
    sel_we  = we_q;
    sel_adr = adr_q;
    sel_dat = dat_q;
    sel_oor = oor_q;
    if (state_q == IDLE) begin
      sel_we  = we_m2s;
      sel_adr = adr_m2s;
      sel_dat = dat_m2s;
      sel_oor = (32'(adr_m2s) >= DEPTH);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      oor_q     <= 1'b0;
      adr_q     <= '0;
      dat_q     <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      rd_ack_q  <= 1'b0;
      txn_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ack_q    <= commit && !sel_oor;
      err_q    <= commit && sel_oor;
      rd_ack_q <= commit && !sel_oor && !sel_we;
      if (cap) begin
        we_q  <= we_m2s;
        adr_q <= adr_m2s;
        dat_q <= dat_m2s;
        oor_q <= (32'(adr_m2s) >= DEPTH);
      end
      if (state_q == RESP) txn_cnt_q <= txn_cnt_q + 1'b1;
    end
  end

  mem_array #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) u_array (
    .clk   (clk),
    .we_i  (commit && sel_we && !sel_oor),
    .re_i  (commit && !sel_we && !sel_oor),
    .adr_i (sel_adr),
    .dat_i (sel_dat),
    .dat_o (rd_dat)
  );

  assign dat_mem_o  = rd_ack_q ? rd_dat : '0;
  assign ack_mem_o  = ack_q;
  assign err_mem_o  = err_q;
  assign txn_cnt_o  = txn_cnt_q;
  assign state_test = state_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench: DEPTH=200/LATENCY=2 instance for the main table and corners,
// plus a LATENCY=0 instance for back-to-back timing and counter wrap.
module tb_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, cyc, we;
  logic [7:0]  adr;
  logic [31:0] dat;
  logic [31:0] dat_o;
  logic        ack_o, err_o;
  logic [15:0] cnt_o;
  logic [1:0]  st_o;

  logic        rst0, cyc0, we0;
  logic [7:0]  adr0;
  logic [31:0] dat0;
  logic [31:0] dat_o0;
  logic        ack_o0, err_o0;
  logic [15:0] cnt_o0;
  logic [1:0]  st_o0;

  mem_responder #(.DW(32), .AW(8), .DEPTH(200), .LATENCY(2)) u_dut (
    .clk(clk), .rst(rst), .cyc_m2s(cyc), .we_m2s(we), .adr_m2s(adr), .dat_m2s(dat),
    .dat_mem_o(dat_o), .ack_mem_o(ack_o), .err_mem_o(err_o), .txn_cnt_o(cnt_o),
    .state_test(st_o)
  );

  mem_responder #(.DW(32), .AW(8), .DEPTH(256), .LATENCY(0)) u_dut0 (
    .clk(clk), .rst(rst0), .cyc_m2s(cyc0), .we_m2s(we0), .adr_m2s(adr0), .dat_m2s(dat0),
    .dat_mem_o(dat_o0), .ack_mem_o(ack_o0), .err_mem_o(err_o0), .txn_cnt_o(cnt_o0),
    .state_test(st_o0)
  );

  int n_checks = 0;
  int n_errors = 0;
  int exp_cnt  = 0;

  typedef struct {
    logic        we;
    logic [7:0]  adr;
    logic [31:0] dat;
    logic        exp_ack;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One full transaction on u_dut starting from IDLE at a negedge; inputs are
  // scrambled after capture to show the latched copies are used.
  task automatic do_txn(input string name, input logic w, input logic [7:0] a,
                        input logic [31:0] d, input logic exp_ack, input logic [31:0] exp_rd);
    int acyc;
    logic g_ack, g_err;
    logic [31:0] g_dat;
    cyc = 1'b1; we = w; adr = a; dat = d;
    acyc = -1; g_ack = 1'b0; g_err = 1'b0; g_dat = '0;
    for (int c = 1; c <= 12 && acyc < 0; c++) begin
      step();
      if (c == 1) begin we = ~w; adr = ~a; dat = ~d; end
      if (ack_o || err_o) begin
        acyc = c; g_ack = ack_o; g_err = err_o; g_dat = dat_o;
      end
    end
    check({name, " resp_cycle"}, acyc, 3);
    check({name, " ack"}, g_ack, exp_ack);
    check({name, " err"}, g_err, !exp_ack);
    if (!w || !exp_ack) check({name, " rdata"}, g_dat, exp_rd);
    check({name, " state_resp"}, st_o, 2'b10);
    cyc = 1'b0;
    step();
    exp_cnt++;
    check({name, " state_turn"}, st_o, 2'b11);
    check({name, " ack_gone"}, {ack_o, err_o}, 2'b00);
    check({name, " txn_cnt"}, cnt_o, 16'(exp_cnt));
    step();
    check({name, " state_idle"}, st_o, 2'b00);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 8'h10, 32'hDEADBEEF, 1'b1, 32'h0};
    vecs[1]  = '{1'b0, 8'h10, 32'h0,        1'b1, 32'hDEADBEEF};
    vecs[2]  = '{1'b0, 8'hC8, 32'h0,        1'b0, 32'h0};
    vecs[3]  = '{1'b1, 8'hC7, 32'h12345678, 1'b1, 32'h0};
    vecs[4]  = '{1'b0, 8'hC7, 32'h0,        1'b1, 32'h12345678};
    vecs[5]  = '{1'b1, 8'hFF, 32'h0000AAAA, 1'b0, 32'h0};
    vecs[6]  = '{1'b1, 8'h05, 32'h00000000, 1'b1, 32'h0};
    vecs[7]  = '{1'b1, 8'h20, 32'h11111111, 1'b1, 32'h0};
    vecs[8]  = '{1'b1, 8'h00, 32'h5A5A5A5A, 1'b1, 32'h0};
    vecs[9]  = '{1'b0, 8'h00, 32'h0,        1'b1, 32'h5A5A5A5A};
    vecs[10] = '{1'b0, 8'h20, 32'h0,        1'b1, 32'h11111111};

    rst = 1'b0; rst0 = 1'b0;
    cyc = 1'b0; we = 1'b0; adr = '0; dat = '0;
    cyc0 = 1'b0; we0 = 1'b0; adr0 = '0; dat0 = '0;

    #2 rst = 1'b1; rst0 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset ack", ack_o, 1'b0);
    check("reset err", err_o, 1'b0);
    check("reset dat", dat_o, 32'h0);
    check("reset state", st_o, 2'b00);
    check("reset txn_cnt", cnt_o, 16'h0);
    rst = 1'b0; rst0 = 1'b0;
    step();
    check("idle state", st_o, 2'b00);
    check("idle ack", ack_o, 1'b0);

    for (int i = 0; i < 11; i++) begin
      do_txn($sformatf("vec%0d", i), vecs[i].we, vecs[i].adr, vecs[i].dat,
             vecs[i].exp_ack, vecs[i].exp_rd);
      if (i == 1) check("txn_cnt after wr+rd", cnt_o, 16'd2);
    end

    // Abort a write to 0x05 during WAIT.
    cyc = 1'b1; we = 1'b1; adr = 8'h05; dat = 32'h1;
    step();
    check("abort state_wait", st_o, 2'b01);
    cyc = 1'b0;
    step();
    check("abort state_idle", st_o, 2'b00);
    check("abort no_ack", {ack_o, err_o}, 2'b00);
    step();
    check("abort no_ack_late", {ack_o, err_o}, 2'b00);
    check("abort txn_cnt", cnt_o, 16'(exp_cnt));
    do_txn("abort readback", 1'b0, 8'h05, 32'h0, 1'b1, 32'h0);

    // Async reset while the responder is presenting an ack.
    cyc = 1'b1; we = 1'b0; adr = 8'h10; dat = 32'h0;
    step(); step(); step();
    check("rst_resp ack_before", ack_o, 1'b1);
    check("rst_resp dat_before", dat_o, 32'hDEADBEEF);
    rst = 1'b1;
    #1;
    check("rst_resp ack_now", ack_o, 1'b0);
    check("rst_resp dat_now", dat_o, 32'h0);
    check("rst_resp txn_cnt_now", cnt_o, 16'h0);
    exp_cnt = 0;
    cyc = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    step();

    // Async reset during WAIT of a write to 0x20: the write must be dropped.
    cyc = 1'b1; we = 1'b1; adr = 8'h20; dat = 32'h22222222;
    step(); step();
    check("rst_wait state_wait", st_o, 2'b01);
    rst = 1'b1;
    #1;
    check("rst_wait state_now", st_o, 2'b00);
    check("rst_wait ack_now", {ack_o, err_o}, 2'b00);
    cyc = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    step();
    check("rst_wait state_after", st_o, 2'b00);
    do_txn("rst_wait readback", 1'b0, 8'h20, 32'h0, 1'b1, 32'h11111111);

    // LATENCY=0, cyc held high: ack c1, TURN c2, capture c3, ack c4.
    cyc0 = 1'b1; we0 = 1'b1; adr0 = 8'h33; dat0 = 32'hCAFEF00D;
    step();
    check("lat0 c1 ack", ack_o0, 1'b1);
    check("lat0 c1 state", st_o0, 2'b10);
    we0 = 1'b0; dat0 = 32'h0;
    step();
    check("lat0 c2 ack", ack_o0, 1'b0);
    check("lat0 c2 state", st_o0, 2'b11);
    step();
    check("lat0 c3 state", st_o0, 2'b00);
    check("lat0 c3 ack", ack_o0, 1'b0);
    step();
    check("lat0 c4 ack", ack_o0, 1'b1);
    check("lat0 c4 rdata", dat_o0, 32'hCAFEF00D);
    cyc0 = 1'b0;
    step();
    check("lat0 txn_cnt", cnt_o0, 16'd2);
    step();

    // Counter wrap: preload near the top, then two back-to-back transactions.
    force u_dut0.txn_cnt_q = 16'hFFFE;
    #1;
    release u_dut0.txn_cnt_q;
    #1;
    check("wrap preload", cnt_o0, 16'hFFFE);
    @(negedge clk);
    cyc0 = 1'b1; we0 = 1'b0; adr0 = 8'h33;
    step();
    check("wrap c1 ack", ack_o0, 1'b1);
    step();
    check("wrap cnt_ffff", cnt_o0, 16'hFFFF);
    step();
    step();
    check("wrap c4 ack", ack_o0, 1'b1);
    cyc0 = 1'b0;
    step();
    check("wrap cnt_zero", cnt_o0, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
